// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line-wide memory responder.
package line_mem_pkg;

  localparam int LINE_W_DEF     = 128;
  localparam int WORDS_PER_LINE = LINE_W_DEF / 32;

  // Fibonacci taps 16,14,13,11 expressed on bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    STALL   = 2'd2
  } state_t;

  // Line number of a byte address; the caller keeps the low log2(DEPTH) bits.
  function automatic logic [31:0] line_index(input logic [31:0] addr);
    return addr >> 4;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// DEPTH x LINE_W line storage: per-32-bit-word write enables, a capture register
// for in-flight reads and a direct read port for the single-cycle return path.
module line_mem_array #(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 we,
  input  logic [LINE_W/32-1:0] byte_en,
  input  logic [LINE_W-1:0]    wr_data,
  input  logic                 cap_en,
  output logic [LINE_W-1:0]    rd_line,
  output logic [LINE_W-1:0]    rd_cap
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LINE_W / 32; k++) begin
        if (byte_en[k]) mem[idx][32*k +: 32] <= wr_data[32*k +: 32];
      end
    end
  end

  // Snapshot at accept so later writes cannot disturb a pending read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_cap <= '0;
    else if (cap_en) rd_cap <= mem[idx];
  end

  assign rd_line = mem[idx];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache refill/writeback port with registered outputs.
// Define LINE_MEM_WAITSTATE_EN to inject 0-3 LFSR-driven wait states per command.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_W     = 128,
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    i_m_addr,
  input  logic                 i_m_read,
  input  logic                 i_m_write,
  input  logic [LINE_W/32-1:0] i_m_byte_en,
  input  logic [LINE_W-1:0]    i_m_writedata,
  output logic [LINE_W-1:0]    o_m_readdata,
  output logic                 o_m_readdata_valid,
  output logic                 o_m_waitrequest,
  output logic                 o_proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 5;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_d, wait_d, perr_d;
  logic [LINE_W-1:0]  rdata_d, rd_line, rd_cap;
  logic [31:0]        idx_full;
  logic [IDX_W-1:0]   idx;
  logic               accept, rd_acc, wr_acc;
  logic [1:0]         extra;
  logic [CNT_W-1:0]   rd_lat;
  logic               unused_addr_bits;

  assign idx_full         = line_index(32'(i_m_addr));
  assign idx              = idx_full[IDX_W-1:0];
  assign unused_addr_bits = ^{idx_full[31:IDX_W], i_m_addr};

  assign accept = (i_m_read | i_m_write) & ~o_m_waitrequest;
  assign rd_acc = accept & i_m_read;
  assign wr_acc = accept & i_m_write & ~i_m_read;

`ifdef LINE_MEM_WAITSTATE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  assign rd_lat = CNT_W'(RD_LATENCY - 1) + CNT_W'(extra);

  line_mem_array #(.LINE_W(LINE_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx     (idx),
    .we      (wr_acc),
    .byte_en (i_m_byte_en),
    .wr_data (i_m_writedata),
    .cap_en  (rd_acc),
    .rd_line (rd_line),
    .rd_cap  (rd_cap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      o_m_readdata       <= '0;
      o_m_readdata_valid <= 1'b0;
      o_m_waitrequest    <= 1'b0;
      o_proto_err        <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      o_m_readdata       <= rdata_d;
      o_m_readdata_valid <= valid_d;
      o_m_waitrequest    <= wait_d;
      o_proto_err        <= perr_d;
    end
  end

  // Counter reaches 0 on the edge that raises valid, so the pulse lands N+latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    rdata_d = o_m_readdata;
    perr_d  = o_proto_err | (accept & i_m_read & i_m_write);
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (rd_lat == '0) begin
            valid_d = 1'b1;
            rdata_d = rd_line;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = rd_lat;
          end
        end else if (wr_acc && extra != 2'd0) begin
          state_d = STALL;
          cnt_d   = CNT_W'(extra);
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          rdata_d = rd_cap;
        end
      end
      STALL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wait_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: reference line model, expected reads
// queued at accept and compared when the valid pulse arrives.
module tb_line_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_m_addr = '0;
  logic         i_m_read = 1'b0;
  logic         i_m_write = 1'b0;
  logic [3:0]   i_m_byte_en = '0;
  logic [127:0] i_m_writedata = '0;
  logic [127:0] o_m_readdata;
  logic         o_m_readdata_valid;
  logic         o_m_waitrequest;
  logic         o_proto_err;

  line_mem_responder dut (
    .clk                (clk),
    .rst                (rst),
    .i_m_addr           (i_m_addr),
    .i_m_read           (i_m_read),
    .i_m_write          (i_m_write),
    .i_m_byte_en        (i_m_byte_en),
    .i_m_writedata      (i_m_writedata),
    .o_m_readdata       (o_m_readdata),
    .o_m_readdata_valid (o_m_readdata_valid),
    .o_m_waitrequest    (o_m_waitrequest),
    .o_proto_err        (o_proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [DEPTH];
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_m_readdata_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 128'd1, 128'd0);
      end else begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - e.acc;
        chk("rd_data", o_m_readdata, e.data);
`ifdef LINE_MEM_WAITSTATE_EN
        chk("rd_lat_range", 128'((lat >= LAT) && (lat <= LAT + 3)), 128'd1);
`else
        chk("rd_lat", 128'(lat), 128'(LAT));
`endif
      end
    end
  end

  function automatic void model_write(input int idx, input logic [3:0] be, input logic [127:0] wd);
    for (int k = 0; k < 4; k++)
      if (be[k]) model[idx][32*k +: 32] = wd[32*k +: 32];
  endfunction

  // Presents a command, holds it through waitrequest, returns the cycle it is accepted in.
  task automatic do_cmd(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [127:0] wd, output int acc);
    int n;
    int idx;
    n = 0;
    @(posedge clk); #1;
    i_m_read = rd; i_m_write = wr; i_m_addr = a; i_m_byte_en = be; i_m_writedata = wd;
    @(negedge clk);
    while (o_m_waitrequest && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (o_m_waitrequest) begin
      chk("accept_timeout", 128'd1, 128'd0);
      acc = -1;
      return;
    end
    acc = cyc;
    idx = int'((a >> 4) % DEPTH);
    if (rd) begin
      exp_t e;
      e.data = model[idx];
      e.acc  = cyc;
      sb.push_back(e);
    end else if (wr) begin
      model_write(idx, be, wd);
    end
  endtask

  task automatic release_cmd();
    @(posedge clk); #1;
    i_m_read = 1'b0; i_m_write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, acc;
    logic [127:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", o_m_readdata, 128'd0);
    chk("rst_valid", 128'(o_m_readdata_valid), 128'd0);
    chk("rst_wait", 128'(o_m_waitrequest), 128'd0);
    chk("rst_perr", 128'(o_proto_err), 128'd0);
    rst = 1'b0;

    // full write then read with waitrequest profile
    do_cmd(1'b0, 1'b1, 32'h40, 4'hF, 128'h0123456789ABCDEF0123456789ABCDEF, acc);
    do_cmd(1'b1, 1'b0, 32'h40, 4'h0, '0, acc);
    release_cmd();
`ifndef LINE_MEM_WAITSTATE_EN
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      chk("wait_hi", 128'(o_m_waitrequest), 128'd1);
    end
    @(negedge clk);
    chk("wait_lo_valid_cycle", 128'(o_m_waitrequest), 128'd0);
`endif
    drain();
    chk("first_read_value", o_m_readdata, 128'h0123456789ABCDEF0123456789ABCDEF);

    // partial write
    do_cmd(1'b0, 1'b1, 32'h80, 4'hF, {128{1'b1}}, acc);
    do_cmd(1'b0, 1'b1, 32'h80, 4'b0101, 128'd0, acc);
    do_cmd(1'b1, 1'b0, 32'h80, 4'h0, '0, acc);
    release_cmd();
    drain();
    chk("partial_value", o_m_readdata, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

    // address wrap and ignored low bits
    do_cmd(1'b0, 1'b1, 32'h10, 4'hF, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, acc);
    do_cmd(1'b1, 1'b0, 32'h10 + DEPTH * 16, 4'h0, '0, acc);
    do_cmd(1'b1, 1'b0, 32'h1F, 4'h0, '0, acc);
    release_cmd();
    drain();
    chk("wrap_value", o_m_readdata, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);

    // back-to-back reads, second held through waitrequest
    do_cmd(1'b0, 1'b1, 32'h20, 4'hF, 128'h22222222_22222222_22222222_22222222, acc);
    do_cmd(1'b0, 1'b1, 32'h30, 4'hF, 128'h33333333_33333333_33333333_33333333, acc);
    do_cmd(1'b1, 1'b0, 32'h20, 4'h0, '0, a1);
    do_cmd(1'b1, 1'b0, 32'h30, 4'h0, '0, a2);
    release_cmd();
`ifndef LINE_MEM_WAITSTATE_EN
    chk("b2b_gap", 128'(a2 - a1), 128'(LAT));
`endif
    drain();

    // read and write together: write dropped, sticky error
    do_cmd(1'b0, 1'b1, 32'h50, 4'hF, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA, acc);
    do_cmd(1'b1, 1'b1, 32'h50, 4'hF, 128'h0, acc);
    release_cmd();
    drain();
    chk("perr_set", 128'(o_proto_err), 128'd1);
    do_cmd(1'b1, 1'b0, 32'h50, 4'h0, '0, acc);
    release_cmd();
    drain();
    chk("perr_write_dropped", o_m_readdata, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA);
    chk("perr_sticky", 128'(o_proto_err), 128'd1);

    // reset two cycles into a read
    do_cmd(1'b0, 1'b1, 32'h70, 4'hF, 128'h77777777_00000000_77777777_11111111, acc);
    do_cmd(1'b1, 1'b0, 32'h70, 4'h0, '0, acc);
    release_cmd();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_rdata", o_m_readdata, 128'd0);
    chk("mid_rst_valid", 128'(o_m_readdata_valid), 128'd0);
    chk("mid_rst_wait", 128'(o_m_waitrequest), 128'd0);
    chk("mid_rst_perr", 128'(o_proto_err), 128'd0);
    repeat (LAT) begin
      @(negedge clk);
      chk("rst_no_valid", 128'(o_m_readdata_valid), 128'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_cmd(1'b1, 1'b0, 32'h70, 4'h0, '0, acc);
    release_cmd();
    drain();
    chk("post_rst_value", o_m_readdata, 128'h77777777_00000000_77777777_11111111);

    // random mix over lines 8..15
    for (int l = 8; l < 16; l++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do_cmd(1'b0, 1'b1, 32'(l * 16), 4'hF, d, acc);
    end
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'd0, 6'd0, 4'($urandom_range(8, 15)), 4'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_cmd(1'b1, 1'b0, a, 4'h0, '0, acc);
      else
        do_cmd(1'b0, 1'b1, a, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, acc);
    end
    release_cmd();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the cache's line-wide refill/writeback port. It accepts the single-command read/write requests issued by the unified I/D cache and services them from an internal line array. Reads complete with a configurable latency, flagged by `o_m_readdata_valid`; `o_m_waitrequest` provides back-pressure. It replaces the zero-latency behavioural memory, so the cache's wait and valid paths are actually exercised.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, line width in bits; fixed multiple of 32
- `DEPTH`, 1024, number of lines stored; power of two
- `RD_LATENCY`, 4, cycles from read acceptance to `o_m_readdata_valid`; legal range 1..15
- `LFSR_SEED`, 16'hACE1, seed for the wait-state injector (only used with the macro)

- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `i_m_addr`  in  ADDR_W  byte address of the line
- `i_m_read`  in  1  read request
- `i_m_write`  in  1  write request
- `i_m_byte_en`  in  LINE_W/32  per-32-bit-word write enable; bit k covers bits [32k+31:32k]
- `i_m_writedata`  in  LINE_W  write line data
- `o_m_readdata`  out  LINE_W  read line data
- `o_m_readdata_valid`  out  1  one-cycle pulse; `o_m_readdata` is valid
- `o_m_waitrequest`  out  1  responder busy; command is not accepted
- `o_proto_err`  out  1  sticky flag: read and write were asserted together

## Operation
- Line index = `i_m_addr[4+log2(DEPTH)-1:4]`. Bits [3:0] are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH lines.
- Command accepted in any cycle where (`i_m_read` | `i_m_write`) & ~`o_m_waitrequest`.
- States:
  - IDLE: accept commands.
  - RD_WAIT: latency counter running.
  - (macro) STALL: injected wait states.
- Write accept:
  - At that edge, words with `i_m_byte_en[k]`=1 are written. Other words are unchanged.
  - FSM stays in IDLE. No response is generated. Writes are zero-latency.
- Read accept:
  - The array line is captured into the read register at the accept edge. A write accepted later does not alter this in-flight data.
  - Counter loads `RD_LATENCY-1`. The FSM goes to RD_WAIT, or stays in IDLE if `RD_LATENCY`=1.
- RD_WAIT: counter decrements each cycle. At 0, assert `o_m_readdata_valid` for exactly one cycle, drive the captured data, and return to IDLE.
- Read and write together: read is accepted, write is dropped, `o_proto_err` is set. Only `rst` clears it.
- `o_m_readdata` holds its last returned value until the next read returns.
- Array contents are not reset.
- Reset mid-read: the in-flight read is discarded, no valid pulse is produced, and the FSM returns to IDLE.

## Timing
- Reset values: `o_m_readdata`=0, `o_m_readdata_valid`=0, `o_m_waitrequest`=0, `o_proto_err`=0, FSM=IDLE, counter=0.
- All outputs are registered.
- Read accepted in cycle N:
  - `o_m_readdata_valid`=1 in cycle N+RD_LATENCY.
  - `o_m_waitrequest`=1 in cycles N+1 .. N+RD_LATENCY-1, and 0 in the valid cycle.
  - A new command can be accepted in the valid cycle, so back-to-back reads issue every RD_LATENCY cycles.
- Write accepted in cycle N: a read accepted in N+1 returns the new data.
- The requester must hold its command stable while `o_m_waitrequest`=1.

## Configuration
- `LINE_MEM_WAITSTATE_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seeded `LFSR_SEED`) advances every cycle.
  - On each accepted command, LFSR[1:0] extra cycles (0-3) are added. For a write, `o_m_waitrequest` is held high for those cycles after the accept, with the FSM in STALL. For a read, they are added to the latency, and `o_m_waitrequest` covers them.
- Not defined: latency is exactly as specified under Timing, and no LFSR or STALL state exists.

## Structure
- Shared package `line_mem_pkg` holds:
  - `WORDS_PER_LINE` = LINE_W/32
  - FSM state encoding (IDLE, RD_WAIT, STALL)
  - the LFSR tap constant
  - the index-slice helper
- One sub-module, `line_mem_array`: DEPTH×LINE_W storage with a word-enable write port and a synchronous read capture. FSM, counter, LFSR and flags stay in `line_mem_responder`.

## Test plan
- Write with addr 0x40, byte_en 4'hF, data 128'h0123…CDEF; then read 0x40 -> valid exactly 4 cycles after accept, data 128'h0123…CDEF, waitrequest high for 3 cycles.
- Partial write: fill line 0x80 with all-ones, then write byte_en 4'b0101 with data all-zero -> read returns 128'hFFFFFFFF_00000000_FFFFFFFF_00000000.
- Wrap: write 0x10 to line index 1, then read 0x10 + DEPTH*16 -> same data returned; addr bits [3:0]=0xF on a read give the identical result.
- Back-to-back reads to lines 2 and 3, with the second held during waitrequest -> second accepted in the first's valid cycle, and valids in cycles N+4 and N+8.
- Read and write asserted together -> read serviced, target line of the write unchanged, `o_proto_err`=1 and sticky until `rst`.
- Assert `rst` 2 cycles into a read -> no valid pulse, all outputs 0; a fresh read after release completes normally.
- With the macro defined: 100 random commands -> every read returns correct data, and observed latency falls in 4..7.
